// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator processor: FETCH/EXEC sequencer, iterative restoring divider,
// one-level CALL/RET link and a program store that is loadable while the core is parked.
module acc_cpu_mc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  prog_we,
   input  logic [ADDR_W-1:0]     prog_addr,
   input  logic [ADDR_W+3:0]     prog_wdata,
   output logic [DATA_W-1:0]     acc,
   output logic [DATA_W-1:0]     ext,
   output logic                  cb,
   output logic [ADDR_W-1:0]     pc,
   output logic                  busy,
   output logic                  halted
);
   localparam int INSTR_W = 4 + ADDR_W;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int CNT_W   = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DIV, S_HALT} state_t;

   state_t              state_r;
   logic [INSTR_W-1:0]  prog_mem_r [DEPTH];
   logic [DATA_W-1:0]   rf_r [DEPTH];
   logic [INSTR_W-1:0]  ir_r;
   logic [ADDR_W-1:0]   link_r;
   logic [DATA_W:0]     div_rem_r;
   logic [DATA_W-1:0]   div_quo_r;
   logic [DATA_W-1:0]   div_dvs_r;
   logic [CNT_W-1:0]    div_cnt_r;

   logic [3:0]          opc_s;
   logic [ADDR_W-1:0]   opnd_s;
   logic [DATA_W-1:0]   ri_s;
   logic                parked_s;
   logic [DATA_W:0]     div_shift_s;
   logic [DATA_W:0]     div_trial_s;
   logic [DATA_W:0]     div_rem_nx_s;
   logic [DATA_W-1:0]   div_quo_nx_s;

   assign opc_s    = ir_r[INSTR_W-1 -: 4];
   assign opnd_s   = ir_r[ADDR_W-1:0];
   assign ri_s     = rf_r[opnd_s];
   assign parked_s = (state_r == S_IDLE) || (state_r == S_HALT);

   // One restoring-division step; a zero divisor never borrows, giving all-ones / original acc
   always_comb begin
      div_shift_s = {div_rem_r[DATA_W-1:0], div_quo_r[DATA_W-1]};
      div_trial_s = div_shift_s - {1'b0, div_dvs_r};
      if (div_trial_s[DATA_W]) begin
         div_rem_nx_s = div_shift_s;
         div_quo_nx_s = {div_quo_r[DATA_W-2:0], 1'b0};
      end else begin
         div_rem_nx_s = div_trial_s;
         div_quo_nx_s = {div_quo_r[DATA_W-2:0], 1'b1};
      end
   end

   // Program store write port, not reset
   always_ff @(posedge clk) begin
      if (prog_we && parked_s) begin
         prog_mem_r[prog_addr] <= prog_wdata;
      end
   end

   // Sequencer, datapath and register file
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= S_IDLE;
         acc       <= DATA_W'(0);
         ext       <= DATA_W'(0);
         cb        <= 1'b0;
         pc        <= ADDR_W'(0);
         busy      <= 1'b0;
         halted    <= 1'b0;
         ir_r      <= INSTR_W'(0);
         link_r    <= ADDR_W'(0);
         div_rem_r <= (DATA_W+1)'(0);
         div_quo_r <= DATA_W'(0);
         div_dvs_r <= DATA_W'(0);
         div_cnt_r <= CNT_W'(0);
         for (int i = 0; i < DEPTH; i++) begin
            rf_r[i] <= DATA_W'(i);
         end
      end else begin
         case (state_r)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state_r <= S_FETCH;
                  pc      <= ADDR_W'(0);
                  busy    <= 1'b1;
                  halted  <= 1'b0;
               end
            end
            S_FETCH: begin
               if (!pause) begin
                  ir_r    <= prog_mem_r[pc];
                  pc      <= pc + ADDR_W'(1);
                  state_r <= S_EXEC;
               end
            end
            S_EXEC: begin
               state_r <= S_FETCH;
               case (opc_s)
                  4'h0: begin
                     case (opnd_s)
                        ADDR_W'(1): acc <= {acc[DATA_W-2:0], 1'b0};
                        ADDR_W'(2): acc <= {1'b0, acc[DATA_W-1:1]};
                        ADDR_W'(3): acc <= {acc[0], acc[DATA_W-1:1]};
                        ADDR_W'(4): acc <= {acc[DATA_W-2:0], acc[DATA_W-1]};
                        ADDR_W'(5): acc <= {acc[DATA_W-1], acc[DATA_W-1:1]};
                        ADDR_W'(6): {cb, acc} <= {1'b0, acc} + (DATA_W+1)'(1);
                        ADDR_W'(7): {cb, acc} <= {1'b0, acc} - (DATA_W+1)'(1);
                        default: begin
                        end
                     endcase
                  end
                  4'h1: {cb, acc} <= {1'b0, acc} + {1'b0, ri_s};
                  4'h2: {cb, acc} <= {1'b0, acc} - {1'b0, ri_s};
                  4'h3: {ext, acc} <= {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, ri_s};
                  4'h4: begin
                     // divisor is captured here so a later STA cannot disturb the iteration
                     div_quo_r <= acc;
                     div_rem_r <= (DATA_W+1)'(0);
                     div_dvs_r <= ri_s;
                     div_cnt_r <= CNT_W'(0);
                     cb        <= (ri_s == DATA_W'(0));
                     state_r   <= S_DIV;
                  end
                  4'h5: acc <= acc & ri_s;
                  4'h6: acc <= acc ^ ri_s;
                  4'h7: cb <= (acc < ri_s);
                  4'h8: begin
                     if (cb) begin
                        pc <= opnd_s;
                     end
                  end
                  4'h9: acc <= ri_s;
                  4'hA: rf_r[opnd_s] <= acc;
                  4'hB: pc <= opnd_s;
                  4'hC: begin
                     link_r <= pc;
                     pc     <= opnd_s;
                  end
                  4'hD: pc <= link_r;
                  4'hF: begin
                     state_r <= S_HALT;
                     busy    <= 1'b0;
                     halted  <= 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
            S_DIV: begin
               div_rem_r <= div_rem_nx_s;
               div_quo_r <= div_quo_nx_s;
               div_cnt_r <= div_cnt_r + CNT_W'(1);
               if (div_cnt_r == CNT_W'(DATA_W - 1)) begin
                  acc     <= div_quo_nx_s;
                  ext     <= div_rem_nx_s[DATA_W-1:0];
                  state_r <= S_FETCH;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
               halted  <= 1'b0;
            end
         endcase
      end
   end
endmodule
